bus_arbiter_8: RTL and testbench
================================

# bus_arbiter_8

Round-robin arbiter and sequencer for a shared 32-bit result bus fed by an internal `mux_8`. Eight requesters each present a request and a 32-bit word. The block picks one winner fairly and drives the `mux_8` select with it. It presents the word downstream under a valid/ready handshake and returns a one-cycle grant to the winner when the word is accepted. It sits between the processor's eight result sources and the single writeback/bus port.

## Interface
Parameters:
- `PTR_INIT`, 0: round-robin pointer value after reset, range 0-7.
- Data width is fixed at 32 bits, matching `mux_8`. It is not parameterised.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `req`  in  8  request vector; bit i belongs to requester i.
- `in0`..`in7`  in  32 each  requester data words.
- `out_ready`  in  1  downstream accepts `out_data` this cycle.
- `out_valid`  out  1  `out_data` is valid.
- `out_data`  out  32  word from the selected requester, produced by `mux_8`.
- `out_src`  out  3  index of the current winner; this is also the `mux_8` select.
- `grant`  out  8  one-hot acknowledge, asserted for one cycle on acceptance.
- `busy`  out  1  high in the HOLD state.

## Operation
- FSM has two states: IDLE and HOLD.
- Internal `ptr` is 3 bits. It holds the first index checked in the next arbitration.
- IDLE:
  - `out_valid`=0 and `grant`=0.
  - If `req` is nonzero, the winner is the first set bit scanning `ptr`, `ptr`+1, ..., `ptr`+7 (mod 8).
  - The winner is registered into `out_src`, and the FSM moves to HOLD.
  - If `req` is zero, the FSM stays in IDLE and `out_src` is unchanged.
- HOLD:
  - `out_valid`=1 and `busy`=1.
  - `out_data` is combinational from `mux_8(select=out_src)`, so it tracks `in[out_src]` every cycle.
  - The requester must hold its data stable while `req` is high.
- Acceptance:
  - Occurs in HOLD when `out_ready`=1 and `req[out_src]`=1.
  - `grant[out_src]`=1 in the same cycle. `grant` is combinational: (state==HOLD) & `out_ready` & `req[out_src]`.
  - Next edge: `ptr` <= `out_src`+1 (mod 8, so 7 wraps to 0) and the FSM moves to IDLE.
- Withdrawal:
  - Occurs in HOLD when `req[out_src]`=0, regardless of `out_ready`.
  - No grant is issued.
  - Next edge: the FSM moves to IDLE and `ptr` is unchanged, so the withdrawn requester keeps its priority.
- Requests from other bits arriving during HOLD are ignored until the next IDLE cycle.
- Only one grant is issued per transaction. `grant` is never multi-hot.

## Timing
- Reset values, applied asynchronously while `reset`=0:
  - FSM state = IDLE, `ptr`=`PTR_INIT`, `out_src`=0.
  - `out_valid`=0, `grant`=0, `busy`=0.
  - `out_data`=`in0`, because the select is 0.
- Reset asserted mid-HOLD aborts the transaction immediately. No grant is issued, and outputs return to their reset values within the same cycle.
- Release of reset is sampled on the first rising edge with `reset`=1.
- Latency: `req` sampled in IDLE gives `out_valid` one cycle later. Grant coincides with the first HOLD cycle that sees `out_ready`=1.
- Throughput: at most one transfer per 2 cycles, since an IDLE cycle always follows HOLD.
- Backpressure: HOLD persists for any number of cycles while `out_ready`=0 and `req[out_src]`=1. `out_src` is stable throughout.
- Requester obligation: drop `req[i]`, or present new data, on the edge after `grant[i]`. A `req[i]` still high in the following IDLE cycle counts as a new request.
- `out_ready` is ignored in IDLE.

## Test plan
- **Single request:** after reset, `req`=8'h20, `in5`=32'hDEADBEEF, `out_ready`=1.
  - Next cycle: `out_valid`=1, `out_src`=5, `out_data`=32'hDEADBEEF, `grant`=8'h20.
  - Following cycle: `out_valid`=0 and `grant`=0.
- **Fairness and wrap:** `PTR_INIT`=0, `req`=8'hFF held, `out_ready`=1.
  - Grants occur every 2 cycles in order 8'h01, 8'h02, ..., 8'h80, then 8'h01 again.
- **Backpressure:** `req`=8'h04, `out_ready`=0 for 4 cycles while `in2` changes 1→2→3.
  - `out_valid` stays 1, `out_data` follows `in2`, `grant`=0 throughout.
  - Raising `out_ready` gives `grant`=8'h04 in that cycle.
- **Withdrawal:** `ptr`=0 and `req`=8'h0A (bits 1 and 3), so 1 wins.
  - Drop `req[1]` during HOLD with `out_ready`=0: FSM goes to IDLE, no grant, `ptr` stays 0.
  - Restore `req`=8'h0A: 1 wins again.
- **Pointer wrap:** after requester 7 is granted, apply `req`=8'h81.
  - Requester 0 wins, `out_src`=0, and `ptr` becomes 1 after its grant.
- **Reset mid-operation:** in HOLD with `out_src`=6 and `out_ready`=0, pulse `reset` low for half a cycle.
  - `out_valid`, `grant` and `out_src` go to 0 immediately.
  - After release with `req`=8'h40, requester 6 is re-arbitrated from `ptr`=`PTR_INIT`.

Source files
------------

// File: rtl/bus_arbiter_8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bus_arbiter_8 : round-robin arbiter driving a shared 32-bit result bus  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+

module mux_8 (
    input  logic [2:0]  sel,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [31:0] in3,
    input  logic [31:0] in4,
    input  logic [31:0] in5,
    input  logic [31:0] in6,
    input  logic [31:0] in7,
    output logic [31:0] out
);
    always_comb begin
        out = in0;
        case (sel)
            3'd0: out = in0;
            3'd1: out = in1;
            3'd2: out = in2;
            3'd3: out = in3;
            3'd4: out = in4;
            3'd5: out = in5;
            3'd6: out = in6;
            3'd7: out = in7;
            default: out = in0;
        endcase
    end
endmodule

module bus_arbiter_8 #(
    parameter int unsigned PTR_INIT = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  req,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [31:0] in3,
    input  logic [31:0] in4,
    input  logic [31:0] in5,
    input  logic [31:0] in6,
    input  logic [31:0] in7,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [2:0]  out_src,
    output logic [7:0]  grant,
    output logic        busy
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [2:0] c_ptr_init = 3'(PTR_INIT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_ptr;
    logic [2:0] w_ptr_nxt;
    logic [2:0] r_src;
    logic [2:0] w_src_nxt;
    logic [2:0] w_winner;
    logic       w_accept;

    // Scan from the farthest offset down so the nearest set bit to r_ptr wins.
    always_comb begin
        w_winner = r_ptr;
        for (int i = 7; i >= 0; i--) begin
            if (req[r_ptr + 3'(i)]) begin
                w_winner = r_ptr + 3'(i);
            end
        end
    end

    assign w_accept = (r_state == HOLD) && out_ready && req[r_src];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ptr   <= c_ptr_init;
            r_src   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_src   <= w_src_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_src_nxt   = r_src;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_src_nxt   = w_winner;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                // A withdrawn request leaves the pointer alone so it keeps priority.
                if (!req[r_src]) begin
                    w_state_nxt = IDLE;
                end else if (out_ready) begin
                    w_ptr_nxt   = r_src + 3'd1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign out_valid = (r_state == HOLD);
    assign busy      = (r_state == HOLD);
    assign out_src   = r_src;
    assign grant     = w_accept ? (8'd1 << r_src) : 8'd0;

    mux_8 u_mux (
        .sel (r_src),
        .in0 (in0),
        .in1 (in1),
        .in2 (in2),
        .in3 (in3),
        .in4 (in4),
        .in5 (in5),
        .in6 (in6),
        .in7 (in7),
        .out (out_data)
    );
endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter_8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bus_arbiter_8 : self-checking bench for bus_arbiter_8                 |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+

module tb_bus_arbiter_8;
    localparam int c_ptr_init = 0;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  req = 8'h00;
    logic [31:0] din [8];
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [2:0]  out_src;
    logic [7:0]  grant;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Reference state: "holding a transaction", rotation start, current winner.
    logic m_hold = 1'b0;
    int   m_ptr  = c_ptr_init;
    int   m_src  = 0;

    bus_arbiter_8 #(.PTR_INIT(c_ptr_init)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .in0       (din[0]),
        .in1       (din[1]),
        .in2       (din[2]),
        .in3       (din[3]),
        .in4       (din[4]),
        .in5       (din[5]),
        .in6       (din[6]),
        .in7       (din[7]),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return 0;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_hold <= 1'b0;
            m_ptr  <= c_ptr_init;
            m_src  <= 0;
        end else if (!m_hold) begin
            if (req != 8'h00) begin
                m_src  <= pick(req, m_ptr);
                m_hold <= 1'b1;
            end
        end else if (!req[m_src]) begin
            m_hold <= 1'b0;
        end else if (out_ready) begin
            m_ptr  <= (m_src + 1) % 8;
            m_hold <= 1'b0;
        end
    end

    always @(negedge clock) begin
        logic [7:0] exp_grant;
        exp_grant = (m_hold && out_ready && req[m_src]) ? 8'(1 << m_src) : 8'h00;
        cmp("model_valid", 32'(out_valid), 32'(m_hold));
        cmp("model_busy",  32'(busy),      32'(m_hold));
        cmp("model_src",   32'(out_src),   32'(m_src));
        cmp("model_data",  out_data,       din[m_src]);
        cmp("model_grant", 32'(grant),     32'(exp_grant));
    end

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] rr_tbl [9];
        rr_tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        for (int i = 0; i < 8; i++) din[i] = 32'h1000_0000 + 32'(i);

        tick();
        @(negedge clock);
        cmp("reset_valid", 32'(out_valid), 32'h0);
        cmp("reset_src",   32'(out_src),   32'h0);
        cmp("reset_data",  out_data,       32'h1000_0000);
        tick();
        reset = 1'b1;

        // single request
        req = 8'h20; din[5] = 32'hDEADBEEF; out_ready = 1'b1;
        tick();
        @(negedge clock);
        cmp("single_valid", 32'(out_valid), 32'h1);
        cmp("single_src",   32'(out_src),   32'h5);
        cmp("single_data",  out_data,       32'hDEADBEEF);
        cmp("single_grant", 32'(grant),     32'h20);
        tick();
        req = 8'h00;
        @(negedge clock);
        cmp("single_after_valid", 32'(out_valid), 32'h0);
        cmp("single_after_grant", 32'(grant),     32'h0);

        // fairness and wrap from a fresh pointer
        tick();
        do_reset();
        req = 8'hFF; out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            @(negedge clock);
            cmp("rr_grant", 32'(grant), 32'(rr_tbl[k]));
            tick();
            @(negedge clock);
            cmp("rr_idle_grant", 32'(grant), 32'h0);
        end
        req = 8'h00;

        // backpressure
        tick();
        req = 8'h04; out_ready = 1'b0; din[2] = 32'd1;
        for (int k = 0; k < 4; k++) begin
            tick();
            din[2] = 32'(k < 3 ? k + 1 : 3);
            @(negedge clock);
            cmp("bp_valid", 32'(out_valid), 32'h1);
            cmp("bp_data",  out_data,       32'(k < 3 ? k + 1 : 3));
            cmp("bp_grant", 32'(grant),     32'h0);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clock);
        cmp("bp_release_grant", 32'(grant), 32'h04);
        tick();
        req = 8'h00;

        // withdrawal keeps the pointer
        tick();
        do_reset();
        req = 8'h0A; out_ready = 1'b0;
        tick();
        @(negedge clock);
        cmp("wd_first_src", 32'(out_src), 32'h1);
        tick();
        req = 8'h08;
        @(negedge clock);
        cmp("wd_no_grant", 32'(grant), 32'h0);
        tick();
        req = 8'h0A;
        @(negedge clock);
        cmp("wd_idle_valid", 32'(out_valid), 32'h0);
        tick();
        @(negedge clock);
        cmp("wd_again_src", 32'(out_src), 32'h1);
        tick();
        out_ready = 1'b1;
        @(negedge clock);
        cmp("wd_grant", 32'(grant), 32'h02);
        tick();
        req = 8'h00;

        // pointer wrap after requester 7
        tick();
        req = 8'h80;
        tick();
        @(negedge clock);
        cmp("wrap_g7", 32'(grant), 32'h80);
        tick();
        req = 8'h81;
        tick();
        @(negedge clock);
        cmp("wrap_src0",   32'(out_src), 32'h0);
        cmp("wrap_grant0", 32'(grant),   32'h01);
        tick();
        req = 8'h03;
        tick();
        @(negedge clock);
        cmp("wrap_ptr1_src", 32'(out_src), 32'h1);
        tick();
        req = 8'h00;

        // reset pulse in HOLD
        tick();
        req = 8'h40; out_ready = 1'b0;
        tick();
        @(negedge clock);
        cmp("rst_hold_src", 32'(out_src), 32'h6);
        tick();
        reset = 1'b0;
        #1;
        cmp("rst_valid", 32'(out_valid), 32'h0);
        cmp("rst_grant", 32'(grant),     32'h0);
        cmp("rst_src",   32'(out_src),   32'h0);
        #4;
        reset = 1'b1;
        tick();
        @(negedge clock);
        cmp("rst_rearb_src", 32'(out_src), 32'h6);
        tick();
        out_ready = 1'b1;
        @(negedge clock);
        cmp("rst_rearb_grant", 32'(grant), 32'h40);
        tick();
        req = 8'h00;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1);
    end
endmodule

`default_nettype wire
